// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter that shares one multi-cycle 32x32->64
// multiplier between NREQ requesters. One operation is in flight at a time.
// The winner gets an ack pulse when its operands are captured. After a fixed
// latency it gets a valid pulse that marks the product on resp_data.
// Optional build macro: MULT_ARB_SIGNED_EN. When it is defined, operands are
// two's complement. The multiplier sees their magnitudes and the sign is
// applied again when the product is captured.
module mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic [NREQ-1:0]   req_ack,
    output logic [NREQ-1:0]   resp_valid,
    output logic [63:0]       resp_data,
    output logic              busy,
    output logic              mul_restart,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [63:0]       mul_result
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   vld_q, vld_d;
    logic [63:0]       data_q, data_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              found;
    logic [PW-1:0]     win;
    logic [PW:0]       cand;
    logic [31:0]       a_sel;
    logic [31:0]       b_sel;
    logic [63:0]       prod_fix;

`ifdef MULT_ARB_SIGNED_EN
    logic              neg_q, neg_d;

    // Magnitude of a 32-bit two's complement value; |0x80000000| stays 0x80000000.
    function automatic logic [31:0] mag32(input logic signed [31:0] v);
        return v[31] ? -v : v;
    endfunction

    // 64-bit two's complement negation of the unsigned magnitude product.
    function automatic logic [63:0] neg64(input logic signed [63:0] v);
        return -v;
    endfunction
`endif

    // Round-robin search: first set req bit starting at the pointer, wrapping mod NREQ.
    always_comb begin
        found = 1'b0;
        win   = rr_q;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
            if (!found && req[cand[PW-1:0]]) begin
                found = 1'b1;
                win   = cand[PW-1:0];
            end
        end
    end

    // Operand selection and sign handling for the winner and the product.
    always_comb begin
        a_sel = req_a[32*win +: 32];
        b_sel = req_b[32*win +: 32];
`ifdef MULT_ARB_SIGNED_EN
        prod_fix = neg_q ? neg64(mul_result) : mul_result;
`else
        prod_fix = mul_result;
`endif
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT -> DONE sequence.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        vld_d   = '0;
        data_d  = data_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef MULT_ARB_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    win_d   = win;
                    rr_d    = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
                    ack_d   = NREQ'(1) << win;
                    state_d = ST_ISSUE;
`ifdef MULT_ARB_SIGNED_EN
                    a_d     = mag32(a_sel);
                    b_d     = mag32(b_sel);
                    neg_d   = a_sel[31] ^ b_sel[31];
`else
                    a_d     = a_sel;
                    b_d     = b_sel;
`endif
                end
            end
            ST_ISSUE: begin
                cnt_d   = CW'(MUL_LAT-1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = prod_fix;
                    vld_d   = NREQ'(1) << win_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation and clears the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            vld_q   <= '0;
            data_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef MULT_ARB_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            a_q     <= a_d;
            b_q     <= b_d;
`ifdef MULT_ARB_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign req_ack     = ack_q;
    assign resp_valid  = vld_q;
    assign resp_data   = data_q;
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign busy        = (state_q != ST_IDLE);
    assign mul_restart = reset | (state_q == ST_ISSUE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter: directed vectors with a behavioural multiplier
// whose product only becomes valid MUL_LAT cycles after restart.
module tb_mult_arbiter;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 5;
`ifdef MULT_ARB_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    req_ack;
    logic [NREQ-1:0]    resp_valid;
    logic [63:0]        resp_data;
    logic               busy;
    logic               mul_restart;
    logic [31:0]        mul_a;
    logic [31:0]        mul_b;
    logic [63:0]        mul_result;

    int tests = 0;
    int fails = 0;

    mult_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .req_ack(req_ack), .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(busy), .mul_restart(mul_restart), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    // Multiplier model: garbage until MUL_LAT cycles after the restart cycle.
    int lat_cnt = 0;
    always @(posedge clk) begin
        if (mul_restart) lat_cnt <= 0;
        else if (lat_cnt < 15) lat_cnt <= lat_cnt + 1;
    end
    assign mul_result = (!mul_restart && lat_cnt >= MUL_LAT-1)
                        ? (64'(mul_a) * 64'(mul_b)) : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Operands for the expected winner; every other slot gets distinct junk.
    task automatic set_ops(input logic [3:0] oh, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = oh[i] ? a : (32'hA5A5_0000 + 32'(i));
            req_b[32*i +: 32] = oh[i] ? b : (32'h5A5A_0000 + 32'(i));
        end
    endtask

    // One full operation, entered and left at a negedge with the DUT idle.
    task automatic run_op(input string nm, input logic [3:0] r, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] oh, input logic [63:0] exp);
        logic [3:0] seen;
        req = r;
        set_ops(oh, a, b);
        @(negedge clk);
        chk({nm, ".ack"}, 64'(req_ack), 64'(oh));
        chk({nm, ".restart"}, 64'(mul_restart), 64'd1);
        req   = '0;
        req_a = {NREQ{32'hDEAD_BEEF}};
        req_b = {NREQ{32'hFEED_FACE}};
        seen  = '0;
        repeat (MUL_LAT) begin
            @(negedge clk);
            seen = seen | resp_valid | req_ack;
        end
        chk({nm, ".quiet"}, 64'(seen), 64'd0);
        @(negedge clk);
        chk({nm, ".valid"}, 64'(resp_valid), 64'(oh));
        chk({nm, ".data"}, resp_data, exp);
        @(negedge clk);
        chk({nm, ".idle"}, {62'd0, busy, |resp_valid}, 64'd0);
        chk({nm, ".hold"}, resp_data, exp);
    endtask

    typedef struct {
        string       nm;
        logic [3:0]  r;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  oh;
        logic [63:0] exp_u;
        logic [63:0] exp_s;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [3:0] seen;
        tbl[0] = '{"ones",   4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001, 64'hFFFF_FFFE_0000_0001, 64'h1};
        tbl[1] = '{"rr2",    4'b0101, 32'd3,         32'd5,         4'b0100, 64'hF,                   64'hF};
        tbl[2] = '{"rr3",    4'b1001, 32'h0001_0000, 32'h0001_0000, 4'b1000, 64'h1_0000_0000,         64'h1_0000_0000};
        tbl[3] = '{"rr0",    4'b1001, 32'hFFFF_FFFF, 32'd2,         4'b0001, 64'h1_FFFF_FFFE,         64'hFFFF_FFFF_FFFF_FFFE};
        tbl[4] = '{"zero",   4'b1000, 32'd0,         32'hFFFF_FFFF, 4'b1000, 64'h0,                   64'h0};
        tbl[5] = '{"minint", 4'b0010, 32'h8000_0000, 32'h8000_0000, 4'b0010, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000};
        tbl[6] = '{"neg3x7", 4'b1111, 32'hFFFF_FFFD, 32'd7,         4'b0100, 64'h0000_0006_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFEB};
        tbl[7] = '{"wrap",   4'b0011, 32'h0001_0001, 32'h0001_0001, 4'b0001, 64'h0000_0001_0002_0001, 64'h0000_0001_0002_0001};
        tbl[8] = '{"rr1",    4'b0011, 32'd7,         32'd6,         4'b0010, 64'h2A,                  64'h2A};

        reset = 1'b1;
        req   = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(negedge clk);
        chk("rst.ack", 64'(req_ack), 64'd0);
        chk("rst.valid", 64'(resp_valid), 64'd0);
        chk("rst.data", resp_data, 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.mul_ab", {mul_a, mul_b}, 64'd0);
        chk("rst.restart", 64'(mul_restart), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.release", 64'(mul_restart), 64'd0);

        for (int v = 0; v < 9; v++)
            run_op(tbl[v].nm, tbl[v].r, tbl[v].a, tbl[v].b, tbl[v].oh,
                   SGN ? tbl[v].exp_s : tbl[v].exp_u);

        // Reset clears data; then all four requesters hold req continuously.
        reset = 1'b1;
        @(negedge clk);
        chk("rst2.data", resp_data, 64'd0);
        reset = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = 32'(i + 1);
            req_b[32*i +: 32] = 32'h10;
        end
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            chk($sformatf("cont%0d.ack", g), 64'(req_ack), 64'(4'b0001 << (g % 4)));
            repeat (MUL_LAT) @(negedge clk);
            @(negedge clk);
            chk($sformatf("cont%0d.valid", g), 64'(resp_valid), 64'(4'b0001 << (g % 4)));
            chk($sformatf("cont%0d.data", g), resp_data, 64'(32'h10 * ((g % 4) + 1)));
            @(negedge clk);
        end

        // Reset during the third WAIT cycle aborts the operation.
        req = 4'b0100;
        set_ops(4'b0100, 32'd5, 32'd5);
        @(negedge clk);
        chk("abort.ack", 64'(req_ack), 64'(4'b0100));
        req = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.data", resp_data, 64'd0);
        chk("abort.restart", 64'(mul_restart), 64'd1);
        reset = 1'b0;
        seen = '0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | resp_valid | req_ack;
        end
        chk("abort.novalid", 64'(seen), 64'd0);
        run_op("after_rst", 4'b1010, 32'd9, 32'd9, 4'b0010, 64'h51);

        // A request raised and dropped while busy is never issued.
        req = 4'b0001;
        set_ops(4'b0001, 32'd3, 32'd4);
        @(negedge clk);
        chk("drop.ack", 64'(req_ack), 64'(4'b0001));
        req = 4'b1000;
        repeat (3) @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("drop.valid", 64'(resp_valid), 64'(4'b0001));
        chk("drop.data", resp_data, 64'd12);
        @(negedge clk);
        @(negedge clk);
        chk("drop.noack", {62'd0, busy, |req_ack}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
